conv_engine: RTL
================

Name: conv_engine

Overview:
- Sequential convolution stage that sits directly upstream of the 7-segment display block.
- Takes a 4x4 unsigned image, a 3x3 kernel and a 2x2 kernel.
- Produces the eight 8-bit results c9_11..c9_22 (3x3 conv, 2x2 output) and c4_11..c4_22 (2x2 conv on the top-left 3x3 region, 2x2 output).
- Uses one shared multiply-accumulate, one term per clock.

Parameters:
- PIX_W, 4, pixel width (unsigned).
- W_W, 4, kernel weight width (unsigned).
- ACC_W, 12, internal accumulator width; must hold 9*(2^PIX_W-1)*(2^W_W-1).

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-low.
- start  in  1  start request; sampled only in IDLE.
- img  in  16*PIX_W  pixel p[r][c] at img[(r*4+c)*PIX_W +: PIX_W], r,c in 0..3.
- k9  in  9*W_W  weight k9[u][v] at k9[(u*3+v)*W_W +: W_W].
- k4  in  4*W_W  weight k4[u][v] at k4[(u*2+v)*W_W +: W_W].
- busy  out  1  computation in progress.
- done  out  1  one-cycle pulse when all eight results are written.
- valid  out  1  all eight outputs are consistent with the last completed run.
- c9_11, c9_12, c9_21, c9_22  out  8 each  3x3 results.
- c4_11, c4_12, c4_21, c4_22  out  8 each  2x2 results.

Behaviour:
- Reset (resetn low, async): state IDLE; busy=0, done=0, valid=0; all eight results=0; accumulator and counters=0.
- Definitions, i,j in {1,2}:
  - c9_ij = sum over u,v in 0..2 of p[i-1+u][j-1+v]*k9[u][v].
  - c4_ij = sum over u,v in 0..1 of p[i-1+u][j-1+v]*k4[u][v].
- FSM states: IDLE, MAC9, MAC4.
- IDLE:
  - If start=1 at edge N: latch img/k9/k4 into operand registers, busy<=1, valid<=0, clear accumulator and term/output counters, go to MAC9.
  - If start=0: hold all outputs.
- MAC9:
  - One term per edge. Output order c9_11, c9_12, c9_21, c9_22; terms u-major then v.
  - On the 9th term of an output, write the finished value to its output register and clear the accumulator in the same edge.
  - After the 36th term (edge N+36), go to MAC4.
- MAC4:
  - Same rule with 4 terms per output, order c4_11..c4_22.
  - At edge N+52 the last result is written; busy<=0, valid<=1, done<=1, state IDLE.
- done is high exactly one cycle (N+52 to N+53).
- Latency: start edge to done edge is 52 clocks, fixed and independent of data.
- Inputs may change freely after edge N; only latched operands are used.
- start while busy is ignored; no queuing.
- start held high continuously: a new run begins on the first IDLE cycle after done, so done and start-acceptance never coincide.
- Output registers update individually as each result completes. valid=0 during that window, so the downstream stage qualifies with valid.
- Width: products are PIX_W+W_W bits, accumulated in ACC_W bits with no overflow possible. Conversion to 8 bits is per the Optional Feature.
- resetn asserted mid-run aborts immediately to reset values; a new run needs a fresh start.

Optional Feature:
- Macro CONV_SATURATE_EN.
- Defined: results above 255 clamp to 255.
- Undefined: results are truncated to bits [7:0] (modulo 256).
- Timing and handshakes are identical in both builds.

Decomposition:
- Shared package conv_pkg holds:
  - FSM state typedef (IDLE/MAC9/MAC4).
  - Constants N_TERMS9=9, N_TERMS4=4, N_OUT=4.
  - Default PIX_W, W_W, ACC_W.
  - Function clip8 (saturate/truncate per macro).
- One sub-module is natural: mac_unit (registered multiply-accumulate with synchronous clear-and-load), instantiated once.
- Operand index generation (u,v,i,j to bit slice) stays in conv_engine.

Test Plan:
- Smoke: all pixels=1, all k9=1, all k4=1, pulse start -> done exactly 52 clocks later; every c9=9, every c4=4; valid=1, busy=0.
- Identity kernel: k9 center=1 (others 0), k4[0][0]=1, p[r][c]=r*4+c -> c9_11=5, c9_12=6, c9_21=9, c9_22=10; c4_11=0, c4_12=1, c4_21=4, c4_22=5.
- Overflow: all pixels=15, all weights=15:
  - With CONV_SATURATE_EN -> all c9=255, all c4=255.
  - Without -> all c9=233 (2025 mod 256), all c4=132 (900 mod 256).
- Start during busy: second start pulse at N+10 and inputs changed at N+1 -> single done at N+52; results reflect operands latched at N.
- Mid-run reset: resetn low at N+20 -> outputs, busy, valid, done all 0 immediately. After release, start with all-ones data -> normal results after 52 clocks.
- Back-to-back: start held high -> done pulses spaced 53 clocks apart; valid drops on each re-accept edge.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: definitions shared by the convolution engine and its MAC unit.
//
// Contents:
//   conv_state_t  - FSM state encoding (IDLE / MAC9 / MAC4)
//   N_TERMS9      - product terms per 3x3 result
//   N_TERMS4      - product terms per 2x2 result
//   N_OUT         - results produced per kernel
//   *_DEF         - default pixel, weight and accumulator widths
//   clip8         - reduces an accumulator value to an 8-bit result
//
// Build option: CONV_SATURATE_EN. When defined, clip8 clamps values above 255
// to 255. When undefined, clip8 keeps bits [7:0] (modulo 256).
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC9 = 2'd1,
    ST_MAC4 = 2'd2
  } conv_state_t;

  localparam int N_TERMS9  = 9;
  localparam int N_TERMS4  = 4;
  localparam int N_OUT     = 4;

  localparam int PIX_W_DEF = 4;
  localparam int W_W_DEF   = 4;
  localparam int ACC_W_DEF = 12;

  // The argument is 32 bits wide so that this one function serves any
  // ACC_W up to 32. Callers zero-extend the accumulator into it.
  function automatic logic [7:0] clip8(input logic [31:0] value);
    logic [7:0] result;
    result = value[7:0];
`ifdef CONV_SATURATE_EN
    if (|value[31:8]) begin
      result = 8'hFF;
    end
`endif
    return result;
  endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// mac_unit: registered multiply-accumulate with a synchronous clear.
//
// Ports:
//   clk, resetn - clock; asynchronous active-low reset
//   clr         - clears the accumulator on the next edge (takes priority over en)
//   en          - adds a*b to the accumulator on the next edge
//   a, b        - unsigned operands
//   sum         - accumulator plus the current product (combinational). The
//                 caller can capture a finished result on the same edge that
//                 adds the final term.
module mac_unit
  import conv_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int W_W   = W_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             en,
  input  logic [PIX_W-1:0] a,
  input  logic [W_W-1:0]   b,
  output logic [ACC_W-1:0] sum
);

  logic [PIX_W+W_W-1:0] prod;
  logic [ACC_W-1:0]     acc_q;
  logic [ACC_W-1:0]     acc_d;

  always_comb begin
    prod  = {{W_W{1'b0}}, a} * {{PIX_W{1'b0}}, b};
    sum   = acc_q + ACC_W'(prod);
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/conv_engine.sv
// conv_engine: sequential 3x3 and 2x2 convolution over a latched 4x4 image.
// A single shared MAC unit adds one product term per clock.
//
// Ports:
//   clk, resetn   - clock; asynchronous active-low reset
//   start         - run request; accepted only while idle
//   img, k9, k4   - packed image, 3x3 kernel and 2x2 kernel (latched on start)
//   busy          - a run is in progress
//   done          - one-cycle pulse when the final result is written
//   valid         - all eight results belong to the last completed run
//   c9_11..c9_22  - 3x3 convolution results
//   c4_11..c4_22  - 2x2 convolution results (top-left 3x3 region)
//
// Build option: CONV_SATURATE_EN selects saturation (defined) or
// truncation (undefined) when results are reduced to 8 bits; see conv_pkg.
module conv_engine
  import conv_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int W_W   = W_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [16*PIX_W-1:0] img,
  input  logic [9*W_W-1:0]  k9,
  input  logic [4*W_W-1:0]  k4,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic [7:0]        c9_11,
  output logic [7:0]        c9_12,
  output logic [7:0]        c9_21,
  output logic [7:0]        c9_22,
  output logic [7:0]        c4_11,
  output logic [7:0]        c4_12,
  output logic [7:0]        c4_21,
  output logic [7:0]        c4_22
);

  conv_state_t          state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 valid_q, valid_d;
  logic [3:0]           term_q, term_d;
  logic [1:0]           out_q, out_d;
  logic [16*PIX_W-1:0]  img_q, img_d;
  logic [9*W_W-1:0]     k9_q, k9_d;
  logic [4*W_W-1:0]     k4_q, k4_d;
  logic [7:0]           c9_q [N_OUT];
  logic [7:0]           c9_d [N_OUT];
  logic [7:0]           c4_q [N_OUT];
  logic [7:0]           c4_d [N_OUT];

  logic [1:0]           u, v;
  logic [1:0]           row, col;
  logic [3:0]           pix_idx;
  logic [3:0]           w9_idx;
  logic [1:0]           w4_idx;
  logic [PIX_W-1:0]     pix;
  logic [W_W-1:0]       weight;
  logic                 last_term;
  logic                 last_out;
  logic                 mac_clr;
  logic                 mac_en;
  logic [ACC_W-1:0]     mac_sum;

  // Turn the term counter into kernel coordinates (u-major, then v). The
  // window origin comes from the output counter: out_q = {i-1, j-1}.
  always_comb begin
    u = 2'd0;
    v = 2'd0;
    if (state_q == ST_MAC4) begin
      u = {1'b0, term_q[1]};
      v = {1'b0, term_q[0]};
    end else begin
      case (term_q)
        4'd0:    begin u = 2'd0; v = 2'd0; end
        4'd1:    begin u = 2'd0; v = 2'd1; end
        4'd2:    begin u = 2'd0; v = 2'd2; end
        4'd3:    begin u = 2'd1; v = 2'd0; end
        4'd4:    begin u = 2'd1; v = 2'd1; end
        4'd5:    begin u = 2'd1; v = 2'd2; end
        4'd6:    begin u = 2'd2; v = 2'd0; end
        4'd7:    begin u = 2'd2; v = 2'd1; end
        default: begin u = 2'd2; v = 2'd2; end
      endcase
    end
    row     = {1'b0, out_q[1]} + u;
    col     = {1'b0, out_q[0]} + v;
    pix_idx = {row, col};
    w9_idx  = ({2'b00, u} * 4'd3) + {2'b00, v};
    w4_idx  = {u[0], v[0]};
    pix     = img_q[pix_idx*PIX_W +: PIX_W];
    weight  = (state_q == ST_MAC4) ? k4_q[w4_idx*W_W +: W_W]
                                   : k9_q[w9_idx*W_W +: W_W];
    last_term = (state_q == ST_MAC4) ? (term_q == 4'(N_TERMS4 - 1))
                                     : (term_q == 4'(N_TERMS9 - 1));
    last_out  = (out_q == 2'(N_OUT - 1));
  end

  mac_unit #(
    .PIX_W (PIX_W),
    .W_W   (W_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk    (clk),
    .resetn (resetn),
    .clr    (mac_clr),
    .en     (mac_en),
    .a      (pix),
    .b      (weight),
    .sum    (mac_sum)
  );

  // Next-state logic. On the final term of each result, the value
  // (accumulator + last product) goes straight into its output register and
  // the accumulator is cleared in the same edge, so no bubble cycles occur.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    term_d  = term_q;
    out_d   = out_q;
    img_d   = img_q;
    k9_d    = k9_q;
    k4_d    = k4_q;
    c9_d    = c9_q;
    c4_d    = c4_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          img_d   = img;
          k9_d    = k9;
          k4_d    = k4;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          mac_clr = 1'b1;
          term_d  = 4'd0;
          out_d   = 2'd0;
          state_d = ST_MAC9;
        end
      end

      ST_MAC9, ST_MAC4: begin
        mac_en = 1'b1;
        if (last_term) begin
          if (state_q == ST_MAC9) begin
            c9_d[out_q] = clip8(32'(mac_sum));
          end else begin
            c4_d[out_q] = clip8(32'(mac_sum));
          end
          mac_clr = 1'b1;
          term_d  = 4'd0;
          out_d   = out_q + 2'd1;
          if (last_out) begin
            if (state_q == ST_MAC9) begin
              state_d = ST_MAC4;
            end else begin
              busy_d  = 1'b0;
              valid_d = 1'b1;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end else begin
          term_d = term_q + 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      term_q  <= 4'd0;
      out_q   <= 2'd0;
      img_q   <= '0;
      k9_q    <= '0;
      k4_q    <= '0;
      c9_q    <= '{default: 8'h00};
      c4_q    <= '{default: 8'h00};
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      term_q  <= term_d;
      out_q   <= out_d;
      img_q   <= img_d;
      k9_q    <= k9_d;
      k4_q    <= k4_d;
      c9_q    <= c9_d;
      c4_q    <= c4_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign valid = valid_q;
  assign c9_11 = c9_q[0];
  assign c9_12 = c9_q[1];
  assign c9_21 = c9_q[2];
  assign c9_22 = c9_q[3];
  assign c4_11 = c4_q[0];
  assign c4_12 = c4_q[1];
  assign c4_21 = c4_q[2];
  assign c4_22 = c4_q[3];

endmodule
